// File: rtl/clk_lock_supv.sv
// Clock-manager lock supervisor on the raw oscillator: sequences dcm_rst, qualifies lock, gates rstb.
// Define CLK_SUPV_FREQCHK_EN to add an mclk_tgl frequency check while in RUN.
module clk_lock_supv #(
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned STABLE_CNT   = 1024,
    parameter int unsigned MAX_RETRY    = 7,
    parameter int unsigned FC_WINDOW    = 1024,
    parameter int unsigned FC_MIN       = 60,
    parameter int unsigned FC_MAX       = 68
) (
    input  logic       osci,
    input  logic       RESET,
    input  logic       dcm_lock,
    input  logic       mclk_tgl,
    output logic       dcm_rst,
    output logic       rstb,
    output logic       sys_ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [2:0] state
);

    localparam int unsigned MaxA    = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
    localparam int unsigned MaxB    = (STABLE_CNT > FC_WINDOW) ? STABLE_CNT : FC_WINDOW;
    localparam int unsigned MaxLoad = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW    = $clog2(MaxLoad + 1);

    localparam logic [CntW-1:0] LoadHold    = CntW'(RST_HOLD - 1);
    localparam logic [CntW-1:0] LoadTimeout = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] LoadStable  = CntW'(STABLE_CNT - 1);
    localparam logic [CntW-1:0] LoadWindow  = CntW'(FC_WINDOW - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);
    localparam logic [2:0]      MaxRetry    = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        StRstHold  = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      retry_q, retry_d, retry_inc;
    logic            lock_s1_q, lock_s_q;
    logic            dcm_rst_q, rstb_q, sys_ready_q, fail_q;

`ifdef CLK_SUPV_FREQCHK_EN
    localparam int unsigned FcW = $clog2(FC_WINDOW + 1);

    logic           tgl_s1_q, tgl_s_q, tgl_d_q, fc_edge;
    logic [FcW-1:0] fc_cnt_q, fc_cnt_d, fc_sum;
    logic [31:0]    fc_sum32;
    logic           fc_bad;

    assign fc_edge  = tgl_s_q ^ tgl_d_q;
    assign fc_sum   = fc_cnt_q + FcW'(fc_edge);
    assign fc_sum32 = 32'(fc_sum);
    assign fc_bad   = (fc_sum32 < FC_MIN) || (fc_sum32 > FC_MAX);

    always_ff @(posedge osci) begin
        if (RESET) begin
            tgl_s1_q <= 1'b0;
            tgl_s_q  <= 1'b0;
            tgl_d_q  <= 1'b0;
            fc_cnt_q <= '0;
        end else begin
            tgl_s1_q <= mclk_tgl;
            tgl_s_q  <= tgl_s1_q;
            tgl_d_q  <= tgl_s_q;
            fc_cnt_q <= fc_cnt_d;
        end
    end
`else
    logic unused_fc;
    assign unused_fc = ^{mclk_tgl, FC_MIN[0], FC_MAX[0]};
`endif

    // Saturating increment; reaching MAX_RETRY sends the FSM to FAIL anyway.
    assign retry_inc = (retry_q >= MaxRetry) ? MaxRetry : retry_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
`ifdef CLK_SUPV_FREQCHK_EN
        fc_cnt_d = fc_cnt_q;
`endif
        case (state_q)
            StRstHold: begin
                if (cnt_q == '0) begin
                    state_d = StWaitLock;
                    cnt_d   = LoadTimeout;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StWaitLock: begin
                // Lock takes priority over a timeout on the same cycle.
                if (lock_s_q) begin
                    state_d = StStable;
                    cnt_d   = LoadStable;
                end else if (cnt_q == '0) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == MaxRetry) ? StFail : StRstHold;
                    cnt_d   = LoadHold;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StStable: begin
                if (!lock_s_q) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == MaxRetry) ? StFail : StRstHold;
                    cnt_d   = LoadHold;
                end else if (cnt_q == '0) begin
                    state_d = StRun;
                    retry_d = '0;
                    cnt_d   = LoadWindow;
`ifdef CLK_SUPV_FREQCHK_EN
                    fc_cnt_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StRun: begin
                if (!lock_s_q) begin
                    state_d = StRstHold;
                    cnt_d   = LoadHold;
                end
`ifdef CLK_SUPV_FREQCHK_EN
                else if (cnt_q == '0) begin
                    fc_cnt_d = '0;
                    if (fc_bad) begin
                        state_d = StRstHold;
                        cnt_d   = LoadHold;
                    end else begin
                        cnt_d = LoadWindow;
                    end
                end else begin
                    cnt_d    = cnt_q - CntOne;
                    fc_cnt_d = fc_sum;
                end
`endif
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StRstHold;
                cnt_d   = LoadHold;
            end
        endcase
    end

    always_ff @(posedge osci) begin
        if (RESET) begin
            state_q     <= StRstHold;
            cnt_q       <= LoadHold;
            retry_q     <= '0;
            lock_s1_q   <= 1'b0;
            lock_s_q    <= 1'b0;
            dcm_rst_q   <= 1'b1;
            rstb_q      <= 1'b0;
            sys_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lock_s1_q   <= dcm_lock;
            lock_s_q    <= lock_s1_q;
            // Outputs follow the next state so they change on the same edge as state.
            dcm_rst_q   <= (state_d == StRstHold) || (state_d == StFail);
            rstb_q      <= (state_d == StRun);
            sys_ready_q <= (state_d == StRun);
            fail_q      <= (state_d == StFail);
        end
    end

    assign dcm_rst   = dcm_rst_q;
    assign rstb      = rstb_q;
    assign sys_ready = sys_ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_clk_lock_supv.sv
// Bench for clk_lock_supv: directed scenarios plus random lock/reset traffic vs a behavioural model.
module tb_clk_lock_supv;

    localparam int RH = 4, LT = 20, SC = 8, MR = 3;
    localparam int FW = 1024, FMIN = 60, FMAX = 68;

    logic       osci = 1'b0;
    logic       RESET = 1'b1;
    logic       dcm_lock = 1'b0;
    logic       mclk_tgl = 1'b0;
    logic       dcm_rst, rstb, sys_ready, fail;
    logic [2:0] retry_cnt, state;

    clk_lock_supv #(
        .RST_HOLD    (RH),
        .LOCK_TIMEOUT(LT),
        .STABLE_CNT  (SC),
        .MAX_RETRY   (MR),
        .FC_WINDOW   (FW),
        .FC_MIN      (FMIN),
        .FC_MAX      (FMAX)
    ) dut (
        .osci     (osci),
        .RESET    (RESET),
        .dcm_lock (dcm_lock),
        .mclk_tgl (mclk_tgl),
        .dcm_rst  (dcm_rst),
        .rstb     (rstb),
        .sys_ready(sys_ready),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .state    (state)
    );

    always #5 osci = ~osci;

    int n_vec = 0, n_err = 0;
    int tgl_period = 0, tgl_ph = 0;

    // Model: phase number per the state encoding, cycles spent in the phase, attempts used.
    int m_state = 0, m_el = 0, m_retry = 0;
    int m_s1 = 0, m_s2 = 0;
    int m_t1 = 0, m_t2 = 0, m_t3 = 0;
    int m_win_el = 0, m_win_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int give_up();
        m_retry = (m_retry < MR) ? m_retry + 1 : MR;
        return (m_retry == MR) ? 4 : 0;
    endfunction

    task automatic model_step();
        int nxt;
        int edge_seen;
        if (RESET) begin
            m_state = 0; m_el = 0; m_retry = 0;
            m_s1 = 0; m_s2 = 0; m_t1 = 0; m_t2 = 0; m_t3 = 0;
            m_win_el = 0; m_win_cnt = 0;
            return;
        end
        nxt = m_state;
        edge_seen = m_t2 ^ m_t3;
        m_el++;
        case (m_state)
            0: if (m_el == RH) nxt = 1;
            1: begin
                if (m_s2 == 1) nxt = 2;
                else if (m_el == LT) nxt = give_up();
            end
            2: begin
                if (m_s2 == 0) nxt = give_up();
                else if (m_el == SC) begin
                    nxt = 3;
                    m_retry = 0;
                end
            end
            3: begin
                if (m_s2 == 0) nxt = 0;
`ifdef CLK_SUPV_FREQCHK_EN
                else begin
                    m_win_el++;
                    m_win_cnt += edge_seen;
                    if (m_win_el == FW) begin
                        if (m_win_cnt < FMIN || m_win_cnt > FMAX) nxt = 0;
                        m_win_el = 0;
                        m_win_cnt = 0;
                    end
                end
`endif
            end
            default: nxt = 4;
        endcase
        if (nxt != m_state) begin
            m_el = 0;
            m_win_el = 0;
            m_win_cnt = 0;
        end
        m_state = nxt;
        m_s2 = m_s1; m_s1 = int'(dcm_lock);
        m_t3 = m_t2; m_t2 = m_t1; m_t1 = int'(mclk_tgl);
    endtask

    task automatic tick();
        logic [3:0] exp_ctl;
        @(posedge osci);
        model_step();
        #1;
        exp_ctl = {(m_state == 0 || m_state == 4), (m_state == 3), (m_state == 3), (m_state == 4)};
        check_eq("state", state, m_state);
        check_eq("retry_cnt", retry_cnt, m_retry);
        check_eq("dcm_rst/rstb/ready/fail", {dcm_rst, rstb, sys_ready, fail}, exp_ctl);
        if (tgl_period > 0) begin
            tgl_ph++;
            if (tgl_ph >= tgl_period) begin
                tgl_ph = 0;
                mclk_tgl = ~mclk_tgl;
            end
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // Advance until the model reaches a phase (bounded), then confirm the DUT agrees.
    task automatic wait_model(input int target, input int bound, input string tag);
        int n = 0;
        while (m_state != target && n < bound) begin
            tick();
            n++;
        end
        check_eq(tag, state, target);
    endtask

    initial begin
        int hold_cnt, n, dropped;

        // Normal lock: dcm_rst width and lock-to-rstb latency.
        do_reset();
        hold_cnt = dcm_rst ? 1 : 0;
        repeat (10) begin
            tick();
            if (dcm_rst) hold_cnt++;
        end
        check_eq("dcm_rst_width", hold_cnt, RH);
        dcm_lock = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rstb && n < 40);
        check_eq("lock_to_rstb_edges", n, 3 + SC);
        check_eq("run_ready", sys_ready, 1);
        check_eq("run_retry", retry_cnt, 0);

        // Loss of lock in RUN: rstb low on the third edge, not before.
        repeat (3) tick();
        dcm_lock = 1'b0;
        repeat (2) tick();
        check_eq("loss_rstb_edge2", rstb, 1);
        tick();
        check_eq("loss_rstb_edge3", rstb, 0);
        check_eq("loss_dcm_rst", dcm_rst, 1);
        check_eq("loss_retry", retry_cnt, 0);

        // Timeouts with lock held low: three attempts then FAIL, sticky until RESET.
        repeat (3 * (RH + LT) + 4) tick();
        check_eq("timeout_fail", fail, 1);
        repeat (10) tick();
        check_eq("fail_dcm_rst", dcm_rst, 1);
        check_eq("fail_retry", retry_cnt, MR);
        do_reset();
        check_eq("reset_from_fail", state, 0);
        check_eq("reset_fail_clr", fail, 0);

        // One-cycle glitch in STABLE restarts the attempt; clean lock then reaches RUN.
        dcm_lock = 1'b1;
        wait_model(2, 50, "reach_stable");
        repeat (3) tick();
        dcm_lock = 1'b0;
        tick();
        dcm_lock = 1'b1;
        wait_model(0, 10, "glitch_to_hold");
        check_eq("glitch_retry", retry_cnt, 1);
        check_eq("glitch_rstb", rstb, 0);
        wait_model(3, 60, "relock_run");
        check_eq("relock_retry", retry_cnt, 0);

        // Lock arrives on the very cycle WAIT_LOCK would time out.
        dcm_lock = 1'b0;
        do_reset();
        repeat (RH + LT - 3) tick();
        dcm_lock = 1'b1;
        repeat (2) tick();
        check_eq("simul_pre", state, 1);
        tick();
        check_eq("simul_lock_wins", state, 2);
        check_eq("simul_retry", retry_cnt, 0);

`ifdef CLK_SUPV_FREQCHK_EN
        // 64 edges per window stays in RUN; about 40 per window drops out.
        wait_model(3, 60, "fc_run");
        tgl_period = 16;
        tgl_ph = 0;
        repeat (FW + 80) tick();
        check_eq("fc_nominal_stays", sys_ready, 1);
        tgl_period = 25;
        dropped = 0;
        repeat (FW + 80) begin
            tick();
            if (!rstb) dropped = 1;
        end
        check_eq("fc_slow_exits", dropped, 1);
`else
        dropped = 0;
`endif

        // Random traffic: lock held for random spans, occasional RESET, mclk_tgl noise.
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            len = $urandom_range(1, 40);
            dcm_lock = ($urandom_range(0, 9) < 7);
            tgl_period = $urandom_range(2, 20);
            if ($urandom_range(0, 24) == 0) do_reset();
            repeat (len) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
